mem_arbiter: RTL

//  Two-port arbiter and sequencer for the 256x8 shared-bus memory. Port 0 is the CPU
//  (fetch/execute); port 1 is the program loader/debug port. Serialises requests and

---
 rtl/mem_arbiter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port arbiter and sequencer for a shared-bus memory: serialises port 0 / port 1
// requests into IDLE -> ACCESS -> DONE transactions and returns data plus a one-cycle ack.
module mem_arbiter #(
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int FIXED_PRI = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_ack,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_ack,
  output logic [DW-1:0] p1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_oe,
  output logic          mem_ie,
  inout  wire  [DW-1:0] bus,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state_q;
  logic          gnt_q;
  logic          last_q;
  logic [AW-1:0] addr_q;
  logic          oe_q;
  logic          ie_q;
  logic [DW-1:0] wdata_q;
  logic          p0_ack_q;
  logic          p1_ack_q;
  logic [DW-1:0] p0_rdata_q;
  logic [DW-1:0] p1_rdata_q;
  logic          busy_q;

  logic          gnt_d;
  logic          sel_we_d;
  logic [AW-1:0] sel_addr_d;
  logic [DW-1:0] sel_wdata_d;

  // Tie-break: round-robin favours the port not granted last; fixed mode always picks port 0.
  always_comb begin
    gnt_d = 1'b0;
    if (p0_req && p1_req) begin
      gnt_d = (FIXED_PRI != 0) ? 1'b0 : ~last_q;
    end else if (p1_req) begin
      gnt_d = 1'b1;
    end
    sel_we_d    = gnt_d ? p1_we    : p0_we;
    sel_addr_d  = gnt_d ? p1_addr  : p0_addr;
    sel_wdata_d = gnt_d ? p1_wdata : p0_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      gnt_q      <= 1'b0;
      last_q     <= 1'b1;
      addr_q     <= '0;
      oe_q       <= 1'b0;
      ie_q       <= 1'b0;
      wdata_q    <= '0;
      p0_ack_q   <= 1'b0;
      p1_ack_q   <= 1'b0;
      p0_rdata_q <= '0;
      p1_rdata_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (p0_req || p1_req) begin
            gnt_q   <= gnt_d;
            last_q  <= gnt_d;
            addr_q  <= sel_addr_d;
            oe_q    <= ~sel_we_d;
            ie_q    <= sel_we_d;
            wdata_q <= sel_wdata_d;
            busy_q  <= 1'b1;
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          // The memory has been driving the bus for a full cycle, so it is settled here.
          if (oe_q) begin
            if (gnt_q) p1_rdata_q <= bus;
            else       p0_rdata_q <= bus;
          end
          p0_ack_q <= ~gnt_q;
          p1_ack_q <= gnt_q;
          oe_q     <= 1'b0;
          ie_q     <= 1'b0;
          state_q  <= DONE;
        end
        DONE: begin
          p0_ack_q <= 1'b0;
          p1_ack_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus      = ie_q ? wdata_q : {DW{1'bz}};
  assign mem_addr = addr_q;
  assign mem_oe   = oe_q;
  assign mem_ie   = ie_q;
  assign p0_ack   = p0_ack_q;
  assign p1_ack   = p1_ack_q;
  assign p0_rdata = p0_rdata_q;
  assign p1_rdata = p1_rdata_q;
  assign busy     = busy_q;

endmodule
